alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer_pkg.sv | 68 ++++++
 rtl/reg_onehot_decoder.sv | 18 +
 rtl/alu_op_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: state codes, opcode
// constants, IR field positions, fault codes and opcode classification helpers.
package alu_op_sequencer_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] ST_T0    = 4'd1;
    localparam logic [STATE_W-1:0] ST_T1    = 4'd2;
    localparam logic [STATE_W-1:0] ST_T2    = 4'd3;
    localparam logic [STATE_W-1:0] ST_T3    = 4'd4;
    localparam logic [STATE_W-1:0] ST_T4    = 4'd5;
    localparam logic [STATE_W-1:0] ST_T5    = 4'd6;
    localparam logic [STATE_W-1:0] ST_T6    = 4'd7;
    localparam logic [STATE_W-1:0] ST_FAULT = 4'd8;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND = 5'b01001;
    localparam logic [OP_W-1:0] OP_OR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT = 5'b10001;

    localparam int REG_IDX_W = 4;

    localparam int IR_OP_MSB = 31;
    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_MSB = 26;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_MSB = 22;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_MSB = 18;
    localparam int IR_RC_LSB = 15;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ILLEGAL = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_e;

    function automatic logic is_binary(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV: r = 1'b1;
            default:                                       r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        logic r;
        case (op)
            OP_NEG, OP_NOT: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // MUL/DIV produce a 64-bit result and need the extra HI write-back step.
    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_onehot_decoder.sv
// Register index to one-hot enable decoder; all outputs low when disabled.
module reg_onehot_decoder #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4
) (
    input  logic                i_en,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [NUM_REGS-1:0] o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
            assign o_onehot[gi] = i_en && (32'(i_idx) == gi);
        end
    endgenerate

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control sequencer for a single-bus datapath: fetch (T0-T2) then
// register/ALU steps (T3-T6), with memory-timeout and illegal-opcode faults.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic [31:0]         ir_in,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [OPCODE_W-1:0] opcode,
    output logic                busy,
    output logic                done,
    output logic [1:0]          fault,
    output logic [15:0]         instr_count
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   w_state_next;
    logic [WAIT_W-1:0]    r_wait;
    logic [WAIT_W-1:0]    w_wait_next;
    logic [WAIT_W-1:0]    w_wait_inc;
    fault_e               r_fault;
    fault_e               w_fault_next;
    logic                 r_done;
    logic                 w_done_next;
    logic [15:0]          r_count;
    logic [15:0]          w_count_next;

    logic [OP_W-1:0]      w_op;
    logic [REG_IDX_W-1:0] w_ra;
    logic [REG_IDX_W-1:0] w_rb;
    logic [REG_IDX_W-1:0] w_rc;
    logic                 w_binary;
    logic                 w_unary;
    logic                 w_muldiv;
    logic                 w_range_ok;
    logic                 w_exec;
    logic                 w_rout_en;
    logic [REG_IDX_W-1:0] w_rout_idx;
    logic                 w_rin_en;
    logic                 w_unused_ir;

    assign w_op        = ir_in[IR_OP_MSB:IR_OP_LSB];
    assign w_ra        = ir_in[IR_RA_MSB:IR_RA_LSB];
    assign w_rb        = ir_in[IR_RB_MSB:IR_RB_LSB];
    assign w_rc        = ir_in[IR_RC_MSB:IR_RC_LSB];
    assign w_unused_ir = ^ir_in[IR_RC_LSB-1:0];

    assign w_binary = is_binary(w_op);
    assign w_unary  = is_unary(w_op);
    assign w_muldiv = is_muldiv(w_op);

    // A 4-bit index always fits a 16-entry file; narrower files must check it.
    generate
        if (NUM_REGS >= (1 << REG_IDX_W)) begin : g_full_file
            assign w_range_ok = 1'b1;
        end else begin : g_part_file
            assign w_range_ok = (32'(w_ra) < NUM_REGS) &&
                                (32'(w_rb) < NUM_REGS) &&
                                (!w_binary || (32'(w_rc) < NUM_REGS));
        end
    endgenerate

    assign w_wait_inc = r_wait + WAIT_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_fault_next = r_fault;
        w_done_next  = 1'b0;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_T0;
                    w_fault_next = FAULT_NONE;
                end
            end
            ST_T0: begin
                w_state_next = ST_T1;
                w_wait_next  = '0;
            end
            ST_T1: begin
                if (mem_ready) begin
                    w_state_next = ST_T2;
                    w_wait_next  = '0;
                end else if (w_wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = FAULT_TIMEOUT;
                    w_wait_next  = '0;
                end else begin
                    w_wait_next = w_wait_inc;
                end
            end
            ST_T2: begin
                // Anything not a clean unary op goes through T3, where faults are raised.
                if (w_unary && w_range_ok) begin
                    w_state_next = ST_T4;
                end else begin
                    w_state_next = ST_T3;
                end
            end
            ST_T3: begin
                if (!(w_binary || w_unary) || !w_range_ok) begin
                    w_state_next = ST_FAULT;
                    w_fault_next = FAULT_ILLEGAL;
                end else begin
                    w_state_next = ST_T4;
                end
            end
            ST_T4: begin
                w_state_next = ST_T5;
            end
            ST_T5: begin
                if (w_muldiv) begin
                    w_state_next = ST_T6;
                end else begin
                    w_state_next = start ? ST_T0 : ST_IDLE;
                    w_done_next  = 1'b1;
                    w_count_next = r_count + 16'd1;
                end
            end
            ST_T6: begin
                w_state_next = start ? ST_T0 : ST_IDLE;
                w_done_next  = 1'b1;
                w_count_next = r_count + 16'd1;
            end
            ST_FAULT: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
            r_fault <= FAULT_NONE;
            r_done  <= 1'b0;
            r_count <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
            r_fault <= w_fault_next;
            r_done  <= w_done_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        case (r_state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            ST_T1: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                // The wait counter is zero only on the first T1 cycle.
                PCin    = (r_wait == '0);
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                Yin = 1'b1;
            end
            ST_T4: begin
                Zin = 1'b1;
            end
            ST_T5: begin
                Zlowout = 1'b1;
                LOin    = w_muldiv;
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_exec     = (r_state == ST_T4) || (r_state == ST_T5) || (r_state == ST_T6);
    assign w_rout_en  = (r_state == ST_T3) || (r_state == ST_T4);
    assign w_rout_idx = ((r_state == ST_T4) && w_binary) ? w_rc : w_rb;
    assign w_rin_en   = (r_state == ST_T5) && !w_muldiv;

    reg_onehot_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rout_dec (
        .i_en     (w_rout_en),
        .i_idx    (w_rout_idx),
        .o_onehot (Rout)
    );

    reg_onehot_decoder #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (REG_IDX_W)
    ) u_rin_dec (
        .i_en     (w_rin_en),
        .i_idx    (w_ra),
        .o_onehot (Rin)
    );

    assign opcode      = w_exec ? OPCODE_W'(w_op) : '0;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign fault       = r_fault;
    assign instr_count = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: randomized and directed instructions against a
// cycle-list reference model built from the sequencing rules.
module tb_alu_op_sequencer;

    localparam int MEM_TIMEOUT = 15;

    localparam logic [4:0] B_ADD = 5'b00011;
    localparam logic [4:0] B_OR  = 5'b01010;
    localparam logic [4:0] B_MUL = 5'b01110;
    localparam logic [4:0] B_NOT = 5'b10001;

    // Strobe bit positions in the packed observation vector.
    localparam logic [13:0] S_PCOUT   = 14'h2000;
    localparam logic [13:0] S_MARIN   = 14'h1000;
    localparam logic [13:0] S_INCPC   = 14'h0800;
    localparam logic [13:0] S_ZIN     = 14'h0400;
    localparam logic [13:0] S_ZLOWOUT = 14'h0200;
    localparam logic [13:0] S_ZHIGH   = 14'h0100;
    localparam logic [13:0] S_PCIN    = 14'h0080;
    localparam logic [13:0] S_READ    = 14'h0040;
    localparam logic [13:0] S_MDRIN   = 14'h0020;
    localparam logic [13:0] S_MDROUT  = 14'h0010;
    localparam logic [13:0] S_IRIN    = 14'h0008;
    localparam logic [13:0] S_YIN     = 14'h0004;
    localparam logic [13:0] S_HIIN    = 14'h0002;
    localparam logic [13:0] S_LOIN    = 14'h0001;

    logic        Clock = 1'b0;
    logic        clear, start, mem_ready;
    logic [31:0] ir_in;
    logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
    logic        MDRin, MDRout, IRin, Yin, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [4:0]  opcode;
    logic        busy, done;
    logic [1:0]  fault;
    logic [15:0] instr_count;

    logic [13:0] obs_sb;
    logic [70:0] all_out;

    assign obs_sb  = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read,
                      MDRin, MDRout, IRin, Yin, HIin, LOin};
    assign all_out = {obs_sb, Rout, Rin, opcode, busy, done, fault, instr_count};

    always #5 Clock = ~Clock;

    alu_op_sequencer #(
        .OPCODE_W    (5),
        .NUM_REGS    (16),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .Clock       (Clock),
        .clear       (clear),
        .start       (start),
        .ir_in       (ir_in),
        .mem_ready   (mem_ready),
        .PCout       (PCout),
        .MARin       (MARin),
        .IncPC       (IncPC),
        .Zin         (Zin),
        .Zlowout     (Zlowout),
        .Zhighout    (Zhighout),
        .PCin        (PCin),
        .Read        (Read),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .IRin        (IRin),
        .Yin         (Yin),
        .HIin        (HIin),
        .LOin        (LOin),
        .Rout        (Rout),
        .Rin         (Rin),
        .opcode      (opcode),
        .busy        (busy),
        .done        (done),
        .fault       (fault),
        .instr_count (instr_count)
    );

    typedef struct {
        logic [13:0] sb;
        logic [15:0] rout;
        bit          rout_chk;
        logic [15:0] rin;
        logic [4:0]  op;
        logic [1:0]  flt;
        bit          mr;
    } cyc_t;

    cyc_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_count = 16'd0;
    bit          m_done_entry = 1'b0;

    // 0 = illegal, 1 = binary, 2 = unary
    function automatic int op_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01110, 5'b01111: return 1;
            5'b10000, 5'b10001: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic cyc_t blank_rec();
        cyc_t r;
        r.sb = '0; r.rout = '0; r.rout_chk = 1'b1; r.rin = '0;
        r.op = '0; r.flt = '0; r.mr = 1'($urandom_range(1));
        return r;
    endfunction

    // Expected busy cycles of one instruction, T0 onwards, plus its fault code.
    task automatic model_instr(input logic [31:0] ir, input int wt, output logic [1:0] flt);
        cyc_t r;
        logic [4:0] op;
        int kind, n1;
        bit muldiv;
        op = ir[31:27];
        kind = op_kind(op);
        muldiv = (op == 5'b01110) || (op == 5'b01111);
        exp_q.delete();
        r = blank_rec(); r.sb = S_PCOUT | S_MARIN | S_INCPC | S_ZIN; exp_q.push_back(r);
        n1 = (wt >= MEM_TIMEOUT) ? MEM_TIMEOUT : wt + 1;
        for (int i = 0; i < n1; i++) begin
            r = blank_rec();
            r.sb = S_ZLOWOUT | S_READ | S_MDRIN | ((i == 0) ? S_PCIN : 14'h0);
            r.mr = (i == wt);
            exp_q.push_back(r);
        end
        if (wt >= MEM_TIMEOUT) begin
            r = blank_rec(); r.flt = 2'd2; exp_q.push_back(r);
            flt = 2'd2;
            return;
        end
        r = blank_rec(); r.sb = S_MDROUT | S_IRIN; exp_q.push_back(r);
        if (kind != 2) begin
            r = blank_rec(); r.sb = S_YIN; r.rout = 16'd1 << ir[22:19]; exp_q.push_back(r);
        end
        if (kind == 0) begin
            r = blank_rec(); r.flt = 2'd1; exp_q.push_back(r);
            flt = 2'd1;
            return;
        end
        r = blank_rec(); r.sb = S_ZIN; r.op = op;
        r.rout = 16'd1 << ((kind == 1) ? ir[18:15] : ir[22:19]);
        exp_q.push_back(r);
        r = blank_rec(); r.op = op; r.rout_chk = 1'b0;
        if (muldiv) r.sb = S_ZLOWOUT | S_LOIN;
        else begin r.sb = S_ZLOWOUT; r.rin = 16'd1 << ir[26:23]; end
        exp_q.push_back(r);
        if (muldiv) begin
            r = blank_rec(); r.sb = S_ZHIGH | S_HIIN; r.op = op; exp_q.push_back(r);
        end
        flt = 2'd0;
    endtask

    // Runs one instruction from a negedge; returns at the negedge after it ends.
    task automatic run_instr(input logic [31:0] ir, input int wt, input bit started,
                             input bit chain, output int busy_cycles, output logic [1:0] flt);
        cyc_t r;
        int n;
        bit completed;
        model_instr(ir, wt, flt);
        n = exp_q.size();
        busy_cycles = 0;
        ir_in = ir;
        if (!started) begin
            start = 1'b1;
            mem_ready = 1'($urandom_range(1));
        end
        for (int k = 0; k < n; k++) begin
            r = exp_q[k];
            if (!(started && k == 0)) @(negedge Clock);
            total++;
            if (busy !== 1'b1) begin bad++; $display("FAIL busy k=%0d got=%b exp=1", k, busy); end
            total++;
            if (obs_sb !== r.sb) begin bad++; $display("FAIL strobes k=%0d got=%h exp=%h", k, obs_sb, r.sb); end
            if (r.rout_chk) begin
                total++;
                if (Rout !== r.rout) begin bad++; $display("FAIL rout k=%0d got=%h exp=%h", k, Rout, r.rout); end
            end
            total++;
            if (Rin !== r.rin) begin bad++; $display("FAIL rin k=%0d got=%h exp=%h", k, Rin, r.rin); end
            total++;
            if (opcode !== r.op) begin bad++; $display("FAIL opcode k=%0d got=%b exp=%b", k, opcode, r.op); end
            total++;
            if (fault !== r.flt) begin bad++; $display("FAIL fault k=%0d got=%0d exp=%0d", k, fault, r.flt); end
            total++;
            if (instr_count !== m_count) begin bad++; $display("FAIL count k=%0d got=%0d exp=%0d", k, instr_count, m_count); end
            total++;
            if (done !== ((k == 0) ? m_done_entry : 1'b0)) begin
                bad++; $display("FAIL done k=%0d got=%b exp=%b", k, done, (k == 0) ? m_done_entry : 1'b0);
            end
            if (busy === 1'b1) busy_cycles++;
            mem_ready = r.mr;
            start = (k == n - 1) ? (chain && flt == 2'd0) : 1'($urandom_range(1));
        end
        @(negedge Clock);
        completed = (flt == 2'd0);
        if (completed) m_count = m_count + 16'd1;
        total++;
        if (done !== completed) begin bad++; $display("FAIL end_done got=%b exp=%b", done, completed); end
        total++;
        if (busy !== (completed && chain)) begin bad++; $display("FAIL end_busy got=%b exp=%b", busy, completed && chain); end
        total++;
        if (instr_count !== m_count) begin bad++; $display("FAIL end_count got=%0d exp=%0d", instr_count, m_count); end
        total++;
        if (fault !== flt) begin bad++; $display("FAIL end_fault got=%0d exp=%0d", fault, flt); end
        if (!(completed && chain)) begin
            total++;
            if ({obs_sb, Rout, Rin, opcode} !== '0) begin
                bad++; $display("FAIL idle_strobes got=%h exp=0", {obs_sb, Rout, Rin, opcode});
            end
        end
        m_done_entry = completed && chain;
        if (!m_done_entry) start = 1'b0;
        $display("instr ir=%08h wait=%0d fault=%0d busy_cycles=%0d count=%0d", ir, wt, flt, busy_cycles, m_count);
    endtask

    task automatic test_reset();
        clear = 1'b1; start = 1'b1; mem_ready = 1'b1; ir_in = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (all_out !== '0) begin bad++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", i, all_out); end
        end
        clear = 1'b0; start = 1'b0;
        m_count = 16'd0; m_done_entry = 1'b0;
    endtask

    task automatic test_directed_or();
        int bc; logic [1:0] f;
        run_instr({B_OR, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 1'b0, 1'b0, bc, f);
        total++;
        if (bc !== 6) begin bad++; $display("FAIL or_cycles got=%0d exp=6", bc); end
        total++;
        if (instr_count !== 16'd1) begin bad++; $display("FAIL or_count got=%0d exp=1", instr_count); end
    endtask

    task automatic test_directed_mul();
        int bc; logic [1:0] f;
        run_instr({B_MUL, 4'd0, 4'd4, 4'd5, 15'd0}, 0, 1'b0, 1'b0, bc, f);
        total++;
        if (bc !== 7) begin bad++; $display("FAIL mul_cycles got=%0d exp=7", bc); end
    endtask

    task automatic test_directed_not();
        int bc; logic [1:0] f;
        run_instr({B_NOT, 4'd6, 4'd7, 4'd0, 15'd0}, 0, 1'b0, 1'b0, bc, f);
        total++;
        if (bc !== 5) begin bad++; $display("FAIL not_cycles got=%0d exp=5", bc); end
    endtask

    task automatic test_timeout();
        int bc; logic [1:0] f; logic [15:0] c0;
        c0 = m_count;
        run_instr({B_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, 20, 1'b0, 1'b0, bc, f);
        total++;
        if (fault !== 2'd2) begin bad++; $display("FAIL timeout_fault got=%0d exp=2", fault); end
        total++;
        if (instr_count !== c0) begin bad++; $display("FAIL timeout_count got=%0d exp=%0d", instr_count, c0); end
        total++;
        if (bc !== 17) begin bad++; $display("FAIL timeout_cycles got=%0d exp=17", bc); end
        run_instr({B_ADD, 4'd4, 4'd5, 4'd6, 15'd0}, 14, 1'b0, 1'b0, bc, f);
        total++;
        if (bc !== 20) begin bad++; $display("FAIL wait14_cycles got=%0d exp=20", bc); end
        run_instr({B_ADD, 4'd4, 4'd5, 4'd6, 15'd0}, 15, 1'b0, 1'b0, bc, f);
        total++;
        if (fault !== 2'd2) begin bad++; $display("FAIL wait15_fault got=%0d exp=2", fault); end
    endtask

    task automatic test_illegal();
        int bc; logic [1:0] f; logic [15:0] c0;
        c0 = m_count;
        run_instr({5'b11111, 4'd2, 4'd3, 4'd4, 15'd0}, 0, 1'b0, 1'b0, bc, f);
        total++;
        if (fault !== 2'd1) begin bad++; $display("FAIL illegal_fault got=%0d exp=1", fault); end
        total++;
        if (bc !== 5) begin bad++; $display("FAIL illegal_cycles got=%0d exp=5", bc); end
        total++;
        if (instr_count !== c0) begin bad++; $display("FAIL illegal_count got=%0d exp=%0d", instr_count, c0); end
    endtask

    task automatic test_random();
        logic [4:0] ops[8];
        logic [4:0] op;
        int bc, wt, sel;
        logic [1:0] f;
        ops = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
        for (int i = 0; i < 30; i++) begin
            op = ($urandom_range(4) == 0) ? 5'($urandom) : ops[$urandom_range(7)];
            sel = $urandom_range(9);
            wt = (sel == 9) ? $urandom_range(20, 15) : ((sel == 8) ? 14 : $urandom_range(3));
            run_instr({op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                      wt, 1'b0, 1'b0, bc, f);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops[8];
        logic [15:0] c0;
        int bc;
        logic [1:0] f;
        ops = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
        c0 = m_count;
        for (int i = 0; i < 4; i++) begin
            run_instr({ops[$urandom_range(7)], 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)},
                      $urandom_range(2), (i > 0), (i < 3), bc, f);
        end
        total++;
        if (instr_count !== c0 + 16'd4) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", instr_count, c0 + 16'd4); end
    endtask

    task automatic test_clear_midway();
        logic [31:0] ir;
        int bc;
        logic [1:0] f;
        ir = {B_ADD, 4'd3, 4'd1, 4'd2, 15'($urandom)};
        ir_in = ir; start = 1'b1; mem_ready = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (4) @(negedge Clock);
        total++;
        if (opcode !== B_ADD || Zin !== 1'b1) begin
            bad++; $display("FAIL midway_t4 got=%b/%b exp=%b/1", opcode, Zin, B_ADD);
        end
        clear = 1'b1; start = 1'b1; mem_ready = 1'b1;
        @(negedge Clock);
        total++;
        if (all_out !== '0) begin bad++; $display("FAIL midway_clear got=%h exp=0", all_out); end
        clear = 1'b0; start = 1'b0;
        m_count = 16'd0; m_done_entry = 1'b0;
        run_instr(ir, 0, 1'b0, 1'b0, bc, f);
        total++;
        if (instr_count !== 16'd1) begin bad++; $display("FAIL midway_count got=%0d exp=1", instr_count); end
        total++;
        if (bc !== 6) begin bad++; $display("FAIL midway_cycles got=%0d exp=6", bc); end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; ir_in = 32'd0;
        test_reset();
        test_directed_or();
        test_directed_mul();
        test_directed_not();
        test_timeout();
        test_illegal();
        test_random();
        test_back_to_back();
        test_clear_midway();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
